sprite_pixel_fetch: RTL and testbench
=====================================

# sprite_pixel_fetch

Read-side front end for the 8-bit sprite SRAMs (e.g. the 64K×8 stage/player image memories) in the Snake display path. The block sits between the VGA timing generator and the memory. It turns raster coordinates into SRAM read addresses for a sprite placed at a movable origin, and compensates for the memory's one-cycle read latency. It expands the returned RGB332 byte to RGB444 with colour-key transparency, and emits a pipelined, tick-aligned pixel stream to the VGA output mux.

## Interface
- `W_LOG2`, 8: sprite width is 2^W_LOG2 pixels.
- `H_LOG2`, 8: sprite height is 2^H_LOG2 lines.
- `ADDR_WIDTH`, 16: SRAM address width. Must equal W_LOG2+H_LOG2.
- `KEY`, 8'hE3: transparent RGB332 value (magenta).

- `clk` in 1: system clock (100 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `pixel_tick` in 1: one-clock strobe marking a new pixel; any spacing ≥1 clock.
- `video_on` in 1: active-display flag, qualified by pixel_tick.
- `pix_x`, `pix_y` in 10 each: raster coordinates, qualified by pixel_tick.
- `org_x`, `org_y` in 10 each: requested sprite top-left corner.
- `bg_rgb` in 12: background colour for this pixel, qualified by pixel_tick.
- `sram_en` out 1: read enable, high for fetched pixels.
- `sram_we` out 1: constant 0.
- `sram_addr` out ADDR_WIDTH: read address.
- `sram_data_o` in 8: SRAM read data, one clock after sram_addr.
- `rgb` out 12: output pixel {R4,G4,B4}, held between valids.
- `rgb_valid` out 1: one-clock strobe per input pixel_tick.
- `sprite_hit` out 1: opaque sprite pixel, aligned with rgb_valid.

## Operation
- **Origin shadowing.** On a tick with pix_x==0 and pix_y==0, org_x/org_y are loaded into the shadow registers. That same tick already uses the new values. All other ticks use the shadow values, so a sprite never tears mid-frame.
- **Hit test** (11-bit unsigned arithmetic, no wrap):
  - dx = pix_x − ox and dy = pix_y − oy.
  - hit = video_on ∧ pix_x ≥ ox ∧ dx < 2^W_LOG2 ∧ pix_y ≥ oy ∧ dy < 2^H_LOG2.
  - A sprite that extends past the screen edge is clipped, not wrapped.
- **Address.** sram_addr = {dy[H_LOG2-1:0], dx[W_LOG2-1:0]}, i.e. row-major from the origin.
- **Stage 1** (edge after the tick):
  - sram_addr is registered; sram_en ← tick∧hit.
  - s1_valid ← tick; s1_hit, s1_von and s1_bg are captured.
  - sram_addr holds its value when there is no hit.
- **Stage 2** (next edge): the SRAM registers its data. s2 copies s1.
- **Stage 3** (next edge, output register):
  - rgb_valid ← s2_valid.
  - If the sample is opaque (s2_hit and sram_data_o≠KEY):
    - rgb ← {r,r[2], g,g[2], b,b}, where r=d[7:5], g=d[4:2], b=d[1:0].
    - sprite_hit ← 1.
  - Otherwise, if s2_von, rgb ← s2_bg and sprite_hit ← 0.
  - Otherwise (blanking), rgb ← 12'h000 and sprite_hit ← 0.
  - rgb and sprite_hit update only when s2_valid is set.
- **Stall.** There is none. The pipeline advances every clock and is fully pipelined for back-to-back ticks.

## Timing
- **Latency.** A tick sampled at edge E0 produces rgb_valid high for exactly one clock after edge E2, i.e. 3 clocks after the tick cycle. Order is preserved.
- **sram_en.** Goes high for one clock after E0 for each hit tick.
- **Reset values** (reset_n low, async):
  - sram_en=0, sram_we=0, sram_addr=0.
  - rgb=0, rgb_valid=0, sprite_hit=0.
  - All valid bits and shadow origins are 0.
- **Reset mid-stream.** In-flight pixels are dropped and produce no rgb_valid. The first valid after release comes 3 clocks after the first new tick.
- **Simultaneous events.** An origin change together with a (0,0) tick takes effect on that tick. Any other origin change waits for the next (0,0) tick.
- **Boundaries.**
  - dx = 2^W_LOG2 − 1 is a hit at the maximum column address.
  - dx = 2^W_LOG2 is a miss.
  - Address 2^ADDR_WIDTH − 1 is reachable at the bottom-right pixel and does not wrap into other rows.

## Test plan
1. **Reset.** Assert reset_n=0 mid-stream with ticks every clock → all outputs 0 immediately. After release, no rgb_valid until 3 clocks after the next tick.
2. **Origin and first pixel.** Tick (0,0) with org=(100,50), then tick (100,50) with video_on=1 and SRAM[0x0000]=0xFF → sram_addr=0x0000 and sram_en=1 one clock later. 3 clocks after the tick: rgb=12'hFFF, sprite_hit=1.
3. **Right edge.** Tick (355,50) → sram_addr=0x00FF. Tick (356,50) → sram_en=0, rgb=bg_rgb, sprite_hit=0. Also tick (100,305) → sram_addr=0xFF00.
4. **Transparency and blanking.** SRAM data 0xE3 at a hit → rgb=bg_rgb (e.g. 12'h0A5), sprite_hit=0. Data 0x1C → rgb=12'h0F0. A tick with video_on=0 → rgb=12'h000.
5. **Origin shadowing.** Change org to (0,0) while at line 200 → the next tick at (100,200) still reads addr 0x9600. After the next (0,0) tick, (0,0) reads addr 0x0000.
6. **Throughput and spacing.** 16 consecutive ticks (one per clock) across the sprite → 16 rgb_valid pulses in order, each 3 clocks after its tick. Repeat with ticks every 4 clocks → identical data, valids spaced 4 apart.

Source files
------------

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: raster-to-SRAM read front end for an 8-bit sprite image.
// Maps raster coordinates onto a sprite placed at a per-frame origin and issues
// reads to a one-cycle-latency SRAM. The RGB332 data returned by the SRAM is
// expanded to RGB444. Colour-key pixels fall through to the background colour.
// The pixel stream leaves a three-stage pipeline aligned to pixel_tick.
module sprite_pixel_fetch #(
    parameter int          W_LOG2     = 8,
    parameter int          H_LOG2     = 8,
    parameter int          ADDR_WIDTH = 16,
    parameter logic [7:0]  KEY        = 8'hE3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pixel_tick,
    input  logic                  video_on,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic [9:0]            org_x,
    input  logic [9:0]            org_y,
    input  logic [11:0]           bg_rgb,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [7:0]            sram_data_o,
    output logic [11:0]           rgb,
    output logic                  rgb_valid,
    output logic                  sprite_hit
);

    localparam logic [10:0] W_SPAN = 11'd1 << W_LOG2;
    localparam logic [10:0] H_SPAN = 11'd1 << H_LOG2;

    // RGB332 -> RGB444: replicate the MSB of the 3-bit fields and double the 2-bit blue field
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    // Shadow origin, latched only at the frame-start pixel so the sprite never tears
    logic [9:0]            r_ox;
    logic [9:0]            r_oy;

    logic                  w_frame_start;
    logic [9:0]            w_ox;
    logic [9:0]            w_oy;
    logic [10:0]           w_dx;
    logic [10:0]           w_dy;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic                  r_sram_en;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic                  r_s1_valid;
    logic                  r_s1_hit;
    logic                  r_s1_von;
    logic [11:0]           r_s1_bg;
    logic                  r_s2_valid;
    logic                  r_s2_hit;
    logic                  r_s2_von;
    logic [11:0]           r_s2_bg;
    logic [11:0]           r_rgb;
    logic                  r_rgb_valid;
    logic                  r_sprite_hit;

    // Hit test and address generation; the frame-start tick uses the incoming origin directly
    always_comb begin
        w_frame_start = pixel_tick && (pix_x == 10'd0) && (pix_y == 10'd0);
        if (w_frame_start) begin
            w_ox = org_x;
            w_oy = org_y;
        end else begin
            w_ox = r_ox;
            w_oy = r_oy;
        end
        // 11-bit differences: the guards below reject the negative (wrapped) cases
        w_dx   = {1'b0, pix_x} - {1'b0, w_ox};
        w_dy   = {1'b0, pix_y} - {1'b0, w_oy};
        w_hit  = video_on && (pix_x >= w_ox) && (w_dx < W_SPAN)
                          && (pix_y >= w_oy) && (w_dy < H_SPAN);
        w_addr = {w_dy[H_LOG2-1:0], w_dx[W_LOG2-1:0]};
    end

    // Origin shadow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ox <= 10'd0;
            r_oy <= 10'd0;
        end else if (w_frame_start) begin
            r_ox <= org_x;
            r_oy <= org_y;
        end else begin
            r_ox <= r_ox;
            r_oy <= r_oy;
        end
    end

    // Stage 1: issue the SRAM read and capture the pixel context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sram_en   <= 1'b0;
            r_sram_addr <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_von    <= 1'b0;
            r_s1_bg     <= 12'h000;
        end else begin
            r_sram_en  <= pixel_tick && w_hit;
            r_s1_valid <= pixel_tick;
            r_s1_hit   <= pixel_tick && w_hit;
            r_s1_von   <= video_on;
            r_s1_bg    <= bg_rgb;
            // Address is held across misses to avoid needless bus toggling
            if (pixel_tick && w_hit) begin
                r_sram_addr <= w_addr;
            end else begin
                r_sram_addr <= r_sram_addr;
            end
        end
    end

    // Stage 2: delay the context while the SRAM registers its read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_von   <= 1'b0;
            r_s2_bg    <= 12'h000;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_hit   <= r_s1_hit;
            r_s2_von   <= r_s1_von;
            r_s2_bg    <= r_s1_bg;
        end
    end

    // Stage 3: colour-key and expand the SRAM data; hold the output between valids
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb        <= 12'h000;
            r_rgb_valid  <= 1'b0;
            r_sprite_hit <= 1'b0;
        end else begin
            r_rgb_valid <= r_s2_valid;
            if (r_s2_valid) begin
                if (r_s2_hit && (sram_data_o != KEY)) begin
                    r_rgb        <= rgb332_to_444(sram_data_o);
                    r_sprite_hit <= 1'b1;
                end else if (r_s2_von) begin
                    r_rgb        <= r_s2_bg;
                    r_sprite_hit <= 1'b0;
                end else begin
                    r_rgb        <= 12'h000;
                    r_sprite_hit <= 1'b0;
                end
            end else begin
                r_rgb        <= r_rgb;
                r_sprite_hit <= r_sprite_hit;
            end
        end
    end

    assign sram_en    = r_sram_en;
    assign sram_we    = 1'b0;
    assign sram_addr  = r_sram_addr;
    assign rgb        = r_rgb;
    assign rgb_valid  = r_rgb_valid;
    assign sprite_hit = r_sprite_hit;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench for sprite_pixel_fetch: directed scenarios plus random
// traffic, all compared against a cycle-indexed behavioural reference model.
module tb_sprite_pixel_fetch;

    localparam logic [7:0] KEY  = 8'hE3;
    localparam int         SPAN = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_tick;
    logic        video_on;
    logic [9:0]  pix_x, pix_y, org_x, org_y;
    logic [11:0] bg_rgb;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data_o;
    logic [11:0] rgb;
    logic        rgb_valid, sprite_hit;

    always #5 clk = ~clk;

    sprite_pixel_fetch dut (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .video_on(video_on),
        .pix_x(pix_x), .pix_y(pix_y), .org_x(org_x), .org_y(org_y), .bg_rgb(bg_rgb),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_data_o(sram_data_o), .rgb(rgb), .rgb_valid(rgb_valid), .sprite_hit(sprite_hit)
    );

    // Sprite image memory with one-cycle registered read
    logic [7:0] mem [0:65535];
    always @(posedge clk) sram_data_o <= mem[sram_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    typedef struct { int due; logic [11:0] rgb; logic hit; } exp_t;
    exp_t        q[$];
    int          cyc = 0;
    int          sh_ox = 0, sh_oy = 0;
    logic [15:0] m_addr = 16'h0000;
    logic        m_en = 1'b0;
    logic [11:0] m_rgb = 12'h000;
    logic        m_hit = 1'b0;
    int          cur_ox = 0, cur_oy = 0;

    function automatic logic [11:0] expand(input int d);
        int r, g, b;
        r = d / 32; g = (d / 4) % 8; b = d % 4;
        return 12'((r * 2 + r / 4) * 256 + (g * 2 + g / 4) * 16 + b * 5);
    endfunction

    task automatic model_reset();
        q.delete();
        sh_ox = 0; sh_oy = 0;
        m_addr = 16'h0000; m_en = 1'b0; m_rgb = 12'h000; m_hit = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare every output after the edge
    task automatic cycle(input bit tk, input int x, input int y, input bit von, input logic [11:0] bg);
        int lox, loy, a;
        bit h;
        logic [11:0] v;
        logic vh;
        pixel_tick = tk; pix_x = 10'(x); pix_y = 10'(y); video_on = von;
        org_x = 10'(cur_ox); org_y = 10'(cur_oy); bg_rgb = bg;
        lox = sh_ox; loy = sh_oy;
        if (tk && x == 0 && y == 0) begin lox = cur_ox; loy = cur_oy; end
        h = von && (x >= lox) && (x - lox < SPAN) && (y >= loy) && (y - loy < SPAN);
        a = h ? (y - loy) * SPAN + (x - lox) : 0;
        if (h && mem[a] != KEY) begin v = expand(int'(mem[a])); vh = 1'b1; end
        else if (von) begin v = bg; vh = 1'b0; end
        else begin v = 12'h000; vh = 1'b0; end
        @(posedge clk);
        cyc++;
        if (tk) begin
            sh_ox = lox; sh_oy = loy;
            q.push_back('{cyc + 2, v, vh});
        end
        m_en = tk && h;
        if (tk && h) m_addr = 16'(a);
        #1;
        check("sram_en", sram_en, m_en);
        check("sram_addr", sram_addr, m_addr);
        if (q.size() > 0 && q[0].due == cyc) begin
            check("rgb_valid", rgb_valid, 1'b1);
            m_rgb = q[0].rgb; m_hit = q[0].hit;
            void'(q.pop_front());
        end else begin
            check("rgb_valid", rgb_valid, 1'b0);
        end
        check("rgb", rgb, m_rgb);
        check("sprite_hit", sprite_hit, m_hit);
    endtask

    task automatic tick(input int x, input int y, input bit von, input logic [11:0] bg);
        cycle(1'b1, x, y, von, bg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5, 5, 1'b0, 12'h000);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"}, sram_en, 1'b0);
        check({tag, "_we"}, sram_we, 1'b0);
        check({tag, "_addr"}, sram_addr, 16'h0000);
        check({tag, "_rgb"}, rgb, 12'h000);
        check({tag, "_valid"}, rgb_valid, 1'b0);
        check({tag, "_hit"}, sprite_hit, 1'b0);
    endtask

    logic [11:0] bgs [16];

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 8'($urandom);
        reset_n = 1'b0; pixel_tick = 1'b0; video_on = 1'b0;
        pix_x = 10'd0; pix_y = 10'd0; org_x = 10'd0; org_y = 10'd0; bg_rgb = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Origin load and first sprite pixel
        mem[16'h0000] = 8'hFF;
        cur_ox = 100; cur_oy = 50;
        tick(0, 0, 1'b1, 12'h321);
        idle(3);
        tick(100, 50, 1'b1, 12'h456);
        check("first_addr", sram_addr, 16'h0000);
        check("first_en", sram_en, 1'b1);
        idle(2);
        check("first_rgb", rgb, 12'hFFF);
        check("first_hit", sprite_hit, 1'b1);
        idle(2);

        // Right edge, bottom edge, bottom-right corner
        tick(355, 50, 1'b1, 12'h111);
        check("right_addr", sram_addr, 16'h00FF);
        tick(356, 50, 1'b1, 12'h123);
        check("right_miss_en", sram_en, 1'b0);
        idle(2);
        check("right_miss_rgb", rgb, 12'h123);
        check("right_miss_hit", sprite_hit, 1'b0);
        tick(100, 305, 1'b1, 12'h222);
        check("bottom_addr", sram_addr, 16'hFF00);
        tick(355, 305, 1'b1, 12'h333);
        check("corner_addr", sram_addr, 16'hFFFF);
        tick(100, 306, 1'b1, 12'h444);
        check("below_en", sram_en, 1'b0);
        idle(4);

        // Transparency and blanking
        mem[16'h0001] = KEY;
        mem[16'h0002] = 8'h1C;
        idle(2);
        tick(101, 50, 1'b1, 12'h0A5);
        idle(2);
        check("key_rgb", rgb, 12'h0A5);
        check("key_hit", sprite_hit, 1'b0);
        tick(102, 50, 1'b1, 12'h0A5);
        idle(2);
        check("green_rgb", rgb, 12'h0F0);
        check("green_hit", sprite_hit, 1'b1);
        tick(102, 50, 1'b0, 12'h0A5);
        idle(2);
        check("blank_rgb", rgb, 12'h000);
        idle(2);

        // Origin shadowing: a new origin waits for the next frame start
        cur_ox = 0; cur_oy = 0;
        tick(100, 200, 1'b1, 12'h555);
        check("shadow_addr", sram_addr, 16'h9600);
        tick(0, 0, 1'b1, 12'h555);
        check("reload_addr", sram_addr, 16'h0000);
        check("reload_en", sram_en, 1'b1);
        idle(4);

        // Throughput: back-to-back ticks, then spaced ticks with the same pixels
        cur_ox = 100; cur_oy = 50;
        tick(0, 0, 1'b1, 12'h000);
        for (int i = 0; i < 16; i++) bgs[i] = 12'($urandom);
        for (int i = 0; i < 16; i++) tick(100 + i * 13, 60 + i, 1'b1, bgs[i]);
        idle(4);
        for (int i = 0; i < 16; i++) begin
            tick(100 + i * 13, 60 + i, 1'b1, bgs[i]);
            idle(3);
        end
        idle(2);

        // Random traffic with occasional frame starts and origin changes
        for (int n = 0; n < 600; n++) begin
            int x, y;
            if ($urandom_range(0, 9) == 0) begin
                cur_ox = $urandom_range(0, 639);
                cur_oy = $urandom_range(0, 479);
            end
            if ($urandom_range(0, 24) == 0) begin
                x = 0; y = 0;
            end else begin
                x = sh_ox + $urandom_range(0, 280) - 10;
                y = sh_oy + $urandom_range(0, 280) - 10;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 1023) x = 1023;
                if (y > 1023) y = 1023;
            end
            cycle($urandom_range(0, 2) != 0, x, y, $urandom_range(0, 7) != 0, 12'($urandom));
        end

        // Mid-stream reset with ticks every clock
        cur_ox = 100; cur_oy = 50;
        tick(0, 0, 1'b1, 12'h000);
        for (int i = 0; i < 4; i++) tick(110 + i, 70, 1'b1, 12'h0F0);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            pixel_tick = 1'b1; pix_x = 10'(120 + i); pix_y = 10'd70; video_on = 1'b1;
            @(posedge clk);
            #1;
            check_zero("rsthold");
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        cur_ox = 20; cur_oy = 10;
        tick(0, 0, 1'b1, 12'h777);
        for (int i = 0; i < 6; i++) tick(20 + i, 10 + i, 1'b1, 12'($urandom));
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
